// File: rtl/icache_nway_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway_pipeline
// Brief    : Two-stage blocking N-way set-associative instruction cache with
//            tree-PLRU replacement, flush-tolerant refill and invalidate-all.
// Revision : 1.0
// ============================================================================
module icache_nway_pipeline #(
    parameter int WAYS        = 2,
    parameter int SETS        = 128,
    parameter int LINE_WORDS  = 8,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        cpu_req_i,
    input  logic [31:0]                 virtual_addr_i,
    input  logic [31:0]                 physical_addr_i,
    output logic                        hit_o,
    output logic                        stall_o,
    output logic [32*FETCH_WIDTH-1:0]   inst_o,
    output logic [31:0]                 inst_addr_o,
    output logic [FETCH_WIDTH-1:0]      inst_valid_o,
    output logic                        mem_ren_o,
    output logic [31:0]                 mem_araddr_o,
    input  logic                        mem_rvalid_i,
    input  logic [32*LINE_WORDS-1:0]    mem_rdata_i,
    input  logic                        inv_all_i,
    output logic                        inv_busy_o
);

    localparam int c_OFF_W = $clog2(LINE_WORDS);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_WAY_W = $clog2(WAYS);
    localparam int c_TAG_W = 30 - c_OFF_W - c_IDX_W;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MISS = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;
    localparam logic [1:0] c_ST_INV  = 2'd3;

    logic [1:0]               r_state;
    logic                     r_s2_req;
    logic [31:0]              r_s2_va;
    logic [31:0]              r_s2_pa;
    logic [c_IDX_W-1:0]       r_inv_idx;
    logic                     r_inv_pend;
    logic [WAYS-1:0]          r_valid [SETS];
    logic [WAYS-2:0]          r_plru  [SETS];
    logic [c_TAG_W-1:0]       r_tag_mem  [WAYS][SETS];
    logic [32*LINE_WORDS-1:0] r_data_mem [WAYS][SETS];
    logic [c_TAG_W-1:0]       r_rd_tag  [WAYS];
    logic [32*LINE_WORDS-1:0] r_rd_data [WAYS];

    logic [c_IDX_W-1:0]       w_s2_idx;
    logic [c_OFF_W-1:0]       w_s2_off;
    logic [c_TAG_W-1:0]       w_s2_tag;
    logic [c_IDX_W-1:0]       w_rd_idx;
    logic [WAYS-1:0]          w_set_valid;
    logic [WAYS-2:0]          w_set_plru;
    logic [WAYS-1:0]          w_way_hit;
    logic [c_WAY_W-1:0]       w_hit_way;
    logic [c_WAY_W-1:0]       w_victim;
    logic                     w_lookup;
    logic                     w_hit;
    logic                     w_miss;
    logic                     w_refill;
    logic                     w_deliver;
    logic [32*LINE_WORDS-1:0] w_line;
    logic                     w_unused;

    // Marks the touched way most-recently-used: every node on its path points away from it.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [c_WAY_W-1:0] way);
        logic [WAYS-2:0]    v_bits;
        logic [WAYS-2:0]    v_mask;
        logic [c_WAY_W-1:0] v_sh;
        int                 v_node;
        v_bits = bits;
        v_node = 1;
        for (int l = 0; l < c_WAY_W; l++) begin
            v_sh   = way >> (c_WAY_W - 1 - l);
            v_mask = (WAYS-1)'(1) << (v_node - 1);
            v_bits = v_sh[0] ? (v_bits & ~v_mask) : (v_bits | v_mask);
            v_node = 2 * v_node + (v_sh[0] ? 1 : 0);
        end
        return v_bits;
    endfunction

    assign w_s2_idx    = r_s2_va[c_OFF_W+2 +: c_IDX_W];
    assign w_s2_off    = r_s2_va[2 +: c_OFF_W];
    assign w_s2_tag    = r_s2_pa[31 -: c_TAG_W];
    assign w_rd_idx    = stall_o ? w_s2_idx : virtual_addr_i[c_OFF_W+2 +: c_IDX_W];
    assign w_set_valid = r_valid[w_s2_idx];
    assign w_set_plru  = r_plru[w_s2_idx];
    assign w_unused    = ^r_s2_pa[c_OFF_W+1:0];

    always_comb begin
        w_way_hit = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_way_hit[w] = w_set_valid[w] && (r_rd_tag[w] == w_s2_tag);
            if (w_way_hit[w]) w_hit_way = c_WAY_W'(w);
        end
    end

    always_comb begin
        logic [WAYS-2:0] v_sh;
        int              v_node;
        v_node = 1;
        for (int l = 0; l < c_WAY_W; l++) begin
            v_sh   = w_set_plru >> (v_node - 1);
            v_node = 2 * v_node + (v_sh[0] ? 1 : 0);
        end
        w_victim = c_WAY_W'(v_node - WAYS);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_set_valid[w]) w_victim = c_WAY_W'(w);
        end
    end

    assign w_lookup  = (r_state == c_ST_IDLE) && r_s2_req && !flush;
    assign w_hit     = w_lookup && (|w_way_hit);
    assign w_miss    = w_lookup && !(|w_way_hit);
    assign w_refill  = ((r_state == c_ST_MISS) || (r_state == c_ST_DROP)) && mem_rvalid_i;
    assign w_deliver = w_hit || ((r_state == c_ST_MISS) && mem_rvalid_i && !flush);

    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            c_ST_IDLE: stall_o = w_miss;
            c_ST_MISS,
            c_ST_DROP: stall_o = !mem_rvalid_i;
            c_ST_INV:  stall_o = 1'b1;
            default:   stall_o = 1'b0;
        endcase
    end

    assign hit_o        = w_hit;
    assign inv_busy_o   = (r_state == c_ST_INV);
    assign mem_ren_o    = (r_state == c_ST_MISS) || (r_state == c_ST_DROP);
    assign mem_araddr_o = {r_s2_pa[31:c_OFF_W+2], (c_OFF_W+2)'(0)};
    assign inst_addr_o  = r_s2_va;

    // A refill delivers straight from the bus; a hit from the read-port registers.
    always_comb begin
        logic [32*LINE_WORDS-1:0] v_shift;
        int                       v_pos;
        w_line       = w_hit ? r_rd_data[w_hit_way] : mem_rdata_i;
        inst_o       = '0;
        inst_valid_o = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            v_pos   = int'(w_s2_off) + k;
            v_shift = w_line >> (32 * v_pos);
            if (w_deliver && (v_pos < LINE_WORDS)) begin
                inst_o[32*k +: 32] = v_shift[31:0];
                inst_valid_o[k]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_s2_req   <= 1'b0;
            r_s2_va    <= '0;
            r_s2_pa    <= '0;
            r_inv_idx  <= '0;
            r_inv_pend <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            if (flush) begin
                r_s2_req <= 1'b0;
            end else if (!stall_o) begin
                r_s2_req <= cpu_req_i;
                r_s2_va  <= virtual_addr_i;
                r_s2_pa  <= physical_addr_i;
            end

            if (w_hit) r_plru[w_s2_idx] <= plru_touch(w_set_plru, w_hit_way);
            if (w_refill) begin
                r_valid[w_s2_idx][w_victim] <= 1'b1;
                r_plru[w_s2_idx]            <= plru_touch(w_set_plru, w_victim);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (inv_all_i) begin
                        r_state   <= c_ST_INV;
                        r_inv_idx <= '0;
                    end else if (w_miss) begin
                        r_state <= c_ST_MISS;
                    end
                end
                c_ST_MISS,
                c_ST_DROP: begin
                    if (inv_all_i) r_inv_pend <= 1'b1;
                    if (mem_rvalid_i) begin
                        r_state    <= (r_inv_pend || inv_all_i) ? c_ST_INV : c_ST_IDLE;
                        r_inv_idx  <= '0;
                        r_inv_pend <= 1'b0;
                    end else if (flush) begin
                        r_state <= c_ST_DROP;
                    end
                end
                c_ST_INV: begin
                    r_valid[r_inv_idx] <= '0;
                    if (r_inv_idx == c_IDX_W'(SETS - 1)) begin
                        r_inv_idx <= '0;
                        r_state   <= c_ST_IDLE;
                        for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
                    end else begin
                        r_inv_idx <= r_inv_idx + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Synchronous read port with write-first forwarding of the refill line.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (w_refill && (w_victim == c_WAY_W'(w))) begin
                r_tag_mem[w][w_s2_idx]  <= w_s2_tag;
                r_data_mem[w][w_s2_idx] <= mem_rdata_i;
            end
            if (w_refill && (w_victim == c_WAY_W'(w)) && (w_rd_idx == w_s2_idx)) begin
                r_rd_tag[w]  <= w_s2_tag;
                r_rd_data[w] <= mem_rdata_i;
            end else begin
                r_rd_tag[w]  <= r_tag_mem[w][w_rd_idx];
                r_rd_data[w] <= r_data_mem[w][w_rd_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_nway_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_nway_pipeline
// Brief    : Directed self-checking bench for icache_nway_pipeline (4-way).
// Revision : 1.0
// ============================================================================
module tb_icache_nway_pipeline;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         cpu_req_i;
    logic [31:0]  virtual_addr_i;
    logic [31:0]  physical_addr_i;
    logic         hit_o;
    logic         stall_o;
    logic [63:0]  inst_o;
    logic [31:0]  inst_addr_o;
    logic [1:0]   inst_valid_o;
    logic         mem_ren_o;
    logic [31:0]  mem_araddr_o;
    logic         mem_rvalid_i;
    logic [255:0] mem_rdata_i;
    logic         inv_all_i;
    logic         inv_busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    icache_nway_pipeline #(
        .WAYS(4), .SETS(128), .LINE_WORDS(8), .FETCH_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .cpu_req_i(cpu_req_i),
        .virtual_addr_i(virtual_addr_i), .physical_addr_i(physical_addr_i),
        .hit_o(hit_o), .stall_o(stall_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .inst_valid_o(inst_valid_o), .mem_ren_o(mem_ren_o), .mem_araddr_o(mem_araddr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .inv_all_i(inv_all_i), .inv_busy_o(inv_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wv(input logic [31:0] a);
        return (a & ~32'h3) ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] v_line;
        logic [31:0]  v_base;
        v_base = a & ~32'h1F;
        for (int j = 0; j < 8; j++) v_line[32*j +: 32] = wv(v_base + 32'(4 * j));
        return v_line;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic [31:0] a);
        cpu_req_i       = r;
        virtual_addr_i  = a;
        physical_addr_i = a;
    endtask

    function automatic logic [1:0] exp_valid(input logic [31:0] a);
        return (a[4:2] == 3'd7) ? 2'b01 : 2'b11;
    endfunction

    task automatic do_hit(input string tag, input logic [31:0] a);
        set_req(1'b1, a);
        cyc();
        set_req(1'b0, 32'h0);
        #4;
        chk({tag, "_hit"}, 64'(hit_o), 64'd1);
        chk({tag, "_valid"}, 64'(inst_valid_o), 64'(exp_valid(a)));
        chk({tag, "_w0"}, 64'(inst_o[31:0]), 64'(wv(a)));
        if (a[4:2] != 3'd7) chk({tag, "_w1"}, 64'(inst_o[63:32]), 64'(wv(a + 32'd4)));
        chk({tag, "_addr"}, 64'(inst_addr_o), 64'(a));
        cyc();
    endtask

    task automatic do_miss(input string tag, input logic [31:0] a, input int nwait);
        set_req(1'b1, a);
        cyc();
        set_req(1'b0, 32'h0);
        #4;
        chk({tag, "_stall"}, 64'(stall_o), 64'd1);
        chk({tag, "_nohit"}, 64'(hit_o), 64'd0);
        cyc();
        #4;
        chk({tag, "_ren"}, 64'(mem_ren_o), 64'd1);
        chk({tag, "_araddr"}, 64'(mem_araddr_o), 64'(a & ~32'h1F));
        cyc();
        repeat (nwait) cyc();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = line_of(a);
        #4;
        chk({tag, "_rvalid_stall"}, 64'(stall_o), 64'd0);
        chk({tag, "_rvalid_valid"}, 64'(inst_valid_o), 64'(exp_valid(a)));
        chk({tag, "_rvalid_w0"}, 64'(inst_o[31:0]), 64'(wv(a)));
        cyc();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        int  busy_cnt;
        logic all_stall;
        rst = 1'b1; flush = 1'b0; inv_all_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        set_req(1'b0, 32'h0);
        repeat (2) cyc();
        #4;
        chk("rst_hit", 64'(hit_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_valid", 64'(inst_valid_o), 64'd0);
        chk("rst_inst", inst_o, 64'd0);
        chk("rst_ren", 64'(mem_ren_o), 64'd0);
        chk("rst_araddr", 64'(mem_araddr_o), 64'd0);
        chk("rst_busy", 64'(inv_busy_o), 64'd0);
        chk("rst_iaddr", 64'(inst_addr_o), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Cold miss, refill after a few cycles, then 1-cycle hits including end-of-line.
        do_miss("t1", 32'h0000_1000, 3);
        do_hit("t1_refetch", 32'h0000_1004);
        do_hit("t2_off7", 32'h0000_101C);

        // Flush during an outstanding refill: no delivery, line still installed.
        set_req(1'b1, 32'h0000_2000);
        cyc();
        set_req(1'b0, 32'h0);
        cyc();
        cyc();
        flush = 1'b1;
        #4 chk("t3_ren_flush", 64'(mem_ren_o), 64'd1);
        cyc();
        flush = 1'b0;
        #4;
        chk("t3_drop_ren", 64'(mem_ren_o), 64'd1);
        chk("t3_drop_stall", 64'(stall_o), 64'd1);
        cyc();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = line_of(32'h0000_2000);
        #4 chk("t3_rv_novalid", 64'(inst_valid_o), 64'd0);
        cyc();
        mem_rvalid_i = 1'b0;
        #4;
        chk("t3_after_valid", 64'(inst_valid_o), 64'd0);
        chk("t3_after_ren", 64'(mem_ren_o), 64'd0);
        cyc();
        do_hit("t3_hit", 32'h0000_2000);

        // Flush coinciding with rvalid.
        set_req(1'b1, 32'h0000_5000);
        cyc();
        set_req(1'b0, 32'h0);
        cyc();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = line_of(32'h0000_5000);
        flush = 1'b1;
        #4 chk("fr_novalid", 64'(inst_valid_o), 64'd0);
        cyc();
        mem_rvalid_i = 1'b0;
        flush = 1'b0;
        #4 chk("fr_stall", 64'(stall_o), 64'd0);
        cyc();
        do_hit("fr_hit", 32'h0000_5008);

        // Five tags into set 3: fills ways 0..3, PLRU then picks way 0 (tag 1).
        do_miss("t4_a", 32'h0001_0060, 0);
        do_miss("t4_b", 32'h0002_0060, 0);
        do_miss("t4_c", 32'h0003_0060, 0);
        do_miss("t4_d", 32'h0004_0060, 0);
        do_miss("t4_e", 32'h0005_0060, 1);
        do_hit("t4_hb", 32'h0002_0060);
        do_hit("t4_hc", 32'h0003_0064);
        do_hit("t4_hd", 32'h0004_0068);
        do_hit("t4_he", 32'h0005_006C);
        do_miss("t4_evicted", 32'h0001_0060, 0);

        // Invalidate-all sweep length and its effect.
        inv_all_i = 1'b1;
        cyc();
        inv_all_i = 1'b0;
        busy_cnt  = 0;
        all_stall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #4;
            if (!inv_busy_o) break;
            busy_cnt++;
            if (!stall_o) all_stall = 1'b0;
            cyc();
        end
        chk("t5_busy_len", 64'(busy_cnt), 64'd128);
        chk("t5_stall", 64'(all_stall), 64'd1);
        cyc();
        do_miss("t5_miss_a", 32'h0000_1004, 0);
        do_miss("t5_miss_b", 32'h0002_0060, 0);

        // Back-to-back fetch to the set being refilled sees the new line.
        set_req(1'b1, 32'h0000_30A0);
        cyc();
        set_req(1'b0, 32'h0);
        cyc();
        cyc();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = line_of(32'h0000_30A0);
        set_req(1'b1, 32'h0000_30A8);
        #4;
        chk("t6_rv_stall", 64'(stall_o), 64'd0);
        chk("t6_rv_valid", 64'(inst_valid_o), 64'd3);
        cyc();
        mem_rvalid_i = 1'b0;
        set_req(1'b0, 32'h0);
        #4;
        chk("t6_byp_hit", 64'(hit_o), 64'd1);
        chk("t6_byp_inst", inst_o, {wv(32'h0000_30AC), wv(32'h0000_30A8)});
        cyc();

        // Reset in the middle of a refill; a late rvalid must be ignored.
        set_req(1'b1, 32'h0000_4000);
        cyc();
        set_req(1'b0, 32'h0);
        cyc();
        #4 chk("rm_ren", 64'(mem_ren_o), 64'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #4;
        chk("rm_ren_drop", 64'(mem_ren_o), 64'd0);
        chk("rm_stall", 64'(stall_o), 64'd0);
        cyc();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = line_of(32'h0000_4000);
        #4 chk("rm_late_rv", 64'(inst_valid_o), 64'd0);
        cyc();
        mem_rvalid_i = 1'b0;
        do_miss("rm_refetch", 32'h0000_4000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
